// File: rtl/i2c_init_sequencer.sv
// Register-initialisation sequencer that feeds the DE2-115 I2C master one single-byte write per table entry.
// Optional read-back verification is compiled in when I2C_INIT_VERIFY_EN is defined.
module i2c_init_sequencer #(
    parameter logic [6:0] DEV_ADDR      = 7'h20,
    parameter int         NUM_REGS      = 16,
    parameter int         STARTUP_DELAY = 50000,
    parameter int         REQ_TIMEOUT   = 4096
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        start,
    output logic        seq_busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  tbl_index,
    input  logic [15:0] tbl_data,
    output logic        i2c_request,
    output logic        i2c_wr,
    output logic [7:0]  i2c_length,
    output logic [6:0]  i2c_address,
    output logic [7:0]  i2c_sub_address,
    output logic [7:0]  i2c_tx,
    input  logic        i2c_busy,
    input  logic        i2c_de,
    input  logic [7:0]  i2c_rx
`ifdef I2C_INIT_VERIFY_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam int DW = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
    localparam int TW = $clog2(REQ_TIMEOUT + 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(STARTUP_DELAY - 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(REQ_TIMEOUT);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DELAY, S_LOAD1, S_LOAD2, S_REQ, S_WAIT_LO, S_NEXT,
        S_DONE, S_ERROR, S_VREQ, S_VLO, S_CHECK
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    sub_q, sub_d;
    logic [7:0]    tx_q, tx_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q;
    logic          verr;

`ifdef I2C_INIT_VERIFY_EN
    logic       de_q, de_prev_q;
    logic [7:0] rx_q;
    logic [7:0] cap_q, cap_d;
    logic [7:0] errcnt_q, errcnt_d;
    assign verr      = (errcnt_q != 8'd0);
    assign err_count = errcnt_q;
`else
    logic unused_in;
    assign unused_in = ^{i2c_de, i2c_rx};
    assign verr      = 1'b0;
`endif

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            tmo_q   <= '0;
            idx_q   <= 8'd0;
            sub_q   <= 8'd0;
            tx_q    <= 8'd0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef I2C_INIT_VERIFY_EN
            de_q      <= 1'b0;
            de_prev_q <= 1'b0;
            rx_q      <= 8'd0;
            cap_q     <= 8'd0;
            errcnt_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            tx_q    <= tx_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= i2c_busy;
`ifdef I2C_INIT_VERIFY_EN
            de_q      <= i2c_de;
            de_prev_q <= de_q;
            rx_q      <= i2c_rx;
            cap_q     <= cap_d;
            errcnt_q  <= errcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        tmo_d   = tmo_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        tx_d    = tx_q;
        wr_d    = wr_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef I2C_INIT_VERIFY_EN
        cap_d    = cap_q;
        errcnt_d = errcnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = 8'd0;
                    dly_d   = '0;
                    state_d = S_DELAY;
`ifdef I2C_INIT_VERIFY_EN
                    errcnt_d = 8'd0;
`endif
                end
            end
            S_DELAY: begin
                if (dly_q == DLY_LAST) state_d = S_LOAD1;
                else                   dly_d   = dly_q + DW'(1);
            end
            S_LOAD1: state_d = S_LOAD2;
            S_LOAD2: begin
                // ROM word is valid now: one cycle after tbl_index was presented
                sub_d = tbl_data[15:8];
                tx_d  = tbl_data[7:0];
                wr_d  = 1'b1;
                if (tbl_data == 16'hFFFF) begin
                    done_d  = 1'b1;
                    err_d   = verr;
                    state_d = S_DONE;
                end else begin
                    tmo_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (busy_q) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else tmo_d = tmo_q + TW'(1);
            end
            S_WAIT_LO: begin
                if (!busy_q) begin
`ifdef I2C_INIT_VERIFY_EN
                    wr_d    = 1'b0;
                    tmo_d   = '0;
                    state_d = S_VREQ;
`else
                    state_d = S_NEXT;
`endif
                end else if (tmo_q == TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else tmo_d = tmo_q + TW'(1);
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    err_d   = verr;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_LOAD1;
                end
            end
`ifdef I2C_INIT_VERIFY_EN
            S_VREQ: begin
                if (busy_q) begin
                    tmo_d   = '0;
                    state_d = S_VLO;
                end else if (tmo_q == TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else tmo_d = tmo_q + TW'(1);
            end
            S_VLO: begin
                if (de_q && !de_prev_q) cap_d = rx_q;
                if (!busy_q) state_d = S_CHECK;
                else if (tmo_q == TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else tmo_d = tmo_q + TW'(1);
            end
            S_CHECK: begin
                // mismatches are tallied only; the walk carries on
                if (cap_q != tx_q && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                state_d = S_NEXT;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign seq_busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign done            = done_q;
    assign error           = err_q;
    assign tbl_index       = idx_q;
    assign i2c_request     = (state_q == S_REQ) || (state_q == S_VREQ);
    assign i2c_wr          = wr_q;
    assign i2c_length      = 8'd1;
    assign i2c_address     = DEV_ADDR;
    assign i2c_sub_address = sub_q;
    assign i2c_tx          = tx_q;

endmodule

// File: doc/i2c_init_sequencer.md
# i2c_init_sequencer

Register-initialisation sequencer sitting directly upstream of the I2C master on the DE2-115. After `start`, it waits a power-up delay, then walks an external register table of {sub-address, data} pairs. For each entry it issues one single-byte I2C write transaction to a fixed device address, driving the master's request/WR/length/address/sub-address/tx inputs and consuming its `busy`/`DE`/rx outputs. It reports done or error to system control.

## Interface
Parameters:
- `DEV_ADDR`, 7'h20: 7-bit I2C device address driven on every transaction.
- `NUM_REGS`, 16: number of table entries, range 1..255.
- `STARTUP_DELAY`, 50000: `clk_50` cycles waited after `start` before the first transaction.
- `REQ_TIMEOUT`, 4096: `clk_50` cycles allowed for `i2c_busy` to rise after the request, and again for it to fall.

Ports:
- `clk_50`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; ignored unless in IDLE, DONE or ERROR.
- `seq_busy`  out  1  high from accepted `start` until DONE or ERROR.
- `done`  out  1  high in DONE; cleared by the next accepted `start`.
- `error`  out  1  high in ERROR; cleared by the next accepted `start`.
- `tbl_index`  out  8  table read address.
- `tbl_data`  in  16  table word; {sub_address[15:8], data[7:0]}; registered ROM, 1-cycle latency.
- `i2c_request`  out  1  transaction request to the master.
- `i2c_wr`  out  1  1 = write, 0 = read.
- `i2c_length`  out  8  byte count; always 1.
- `i2c_address`  out  7  equals `DEV_ADDR`.
- `i2c_sub_address`  out  8  register sub-address.
- `i2c_tx`  out  8  write data byte.
- `i2c_busy`  in  1  master busy.
- `i2c_de`  in  1  master byte-done strobe.
- `i2c_rx`  in  8  master receive register.
- `err_count`  out  8  verify mismatches; present only with `I2C_INIT_VERIFY_EN`.

## Operation
- `i2c_busy`, `i2c_de` and `i2c_rx` are registered once on `clk_50` before use.
- States:
  - IDLE: on `start`, clear `done`/`error`/`err_count`, `tbl_index`←0, delay counter←0, go to DELAY.
  - DELAY: count to `STARTUP_DELAY`-1, then go to LOAD.
  - LOAD: 2 cycles; drive `tbl_index`; on the 2nd cycle latch `tbl_data` into `i2c_sub_address`/`i2c_tx`.
    - If the latched word is 16'hFFFF, end the table early and go to DONE.
    - Otherwise go to REQ.
  - REQ: `i2c_wr`=1, `i2c_request`=1; on registered `busy`=1, drop `i2c_request` and go to WAIT_LO.
  - WAIT_LO: on registered `busy`=0, go to VERIFY_REQ (macro defined) or NEXT.
  - NEXT: if `tbl_index`==`NUM_REGS`-1, go to DONE; otherwise increment and go to LOAD.
  - DONE or ERROR: hold the state; `start` restarts from DELAY.
- Timeout: one cycle counter, cleared on entry to REQ and on entry to WAIT_LO. Reaching `REQ_TIMEOUT` sets `error`, drops `i2c_request`, and goes to ERROR.
- Held stable while `i2c_request` or master `busy` is high: `i2c_sub_address`, `i2c_tx`, `i2c_wr`.
- Constant outputs: `i2c_length` is always 8'd1; `i2c_address` is always `DEV_ADDR`.

## Timing
- Reset values:
  - All outputs 0, except `i2c_address`=`DEV_ADDR` and `i2c_length`=1.
  - State is IDLE; counters are 0.
- Reset mid-transaction: outputs return to reset values immediately. The master completes or aborts on its own; the sequencer does not resume.
- `start` → first `i2c_request` rises after `STARTUP_DELAY`+3 cycles (1 IDLE→DELAY + delay + 2 LOAD).
- `i2c_request` falls 2 cycles after `i2c_busy` rises (1 input register + 1 state).
- Between transactions: ≥4 cycles from registered `busy` falling to the next `i2c_request` (WAIT_LO → NEXT → LOAD×2 → REQ).
- `start` outside IDLE/DONE/ERROR: no effect.
- `i2c_de` in write mode: ignored.

## Configuration
- `I2C_INIT_VERIFY_EN` defined: read-back check after each write.
  - Adds states VERIFY_REQ, VERIFY_LO and CHECK.
  - VERIFY_REQ issues the same sub-address with `i2c_wr`=0, using the same handshake and timeout.
  - `i2c_rx` is captured on the registered `i2c_de` rising edge.
  - CHECK compares the captured byte with `i2c_tx`. A mismatch increments `err_count` (saturating at 255) and sets `error` at DONE; the sequence continues.
  - The `err_count` port exists.
- Not defined: no verify states; writes only; no `err_count` port.

## Test plan
- Reset, `NUM_REGS`=3, table {0x0F00,0x0004,0x1741}, master model busy high for 20 cycles per request → 3 writes with sub/tx (0x0F,0x00),(0x00,0x04),(0x17,0x41); `done`=1, `error`=0, `i2c_wr`=1 throughout.
- Entry 1 = 16'hFFFF, `NUM_REGS`=16 → exactly 1 transaction; `done`=1; `tbl_index` stops at 1.
- Master never asserts busy, `REQ_TIMEOUT`=64 → `error`=1 and `i2c_request`=0 at cycle 65 after request rise; no further requests.
- `reset_n` low while master busy on entry 2 → all outputs at reset values the same cycle; `start` then replays from entry 0.
- `I2C_INIT_VERIFY_EN`, entry 0x1741, model returns 0x40 → read issued with `i2c_wr`=0 to sub 0x17; `err_count`=1; `done`=1 and `error`=1.
